// File: rtl/tx_resultado_if.sv
// tx_resultado_if: result-word handshake and serial line between the ALU
// result side (master) and the transmitter (slave).
interface tx_resultado_if #(
    parameter int CANT_BITS_DATO = 8
);
    logic [CANT_BITS_DATO-1:0] i_dato;
    logic                      i_valid;
    logic                      o_ready;
    logic                      o_tx;
    logic                      o_tx_done;

    modport master (
        output i_dato,
        output i_valid,
        input  o_ready,
        input  o_tx,
        input  o_tx_done
    );

    modport slave (
        input  i_dato,
        input  i_valid,
        output o_ready,
        output o_tx,
        output o_tx_done
    );
endinterface

// File: rtl/tx_resultado.sv
// tx_resultado: serializes ALU result words as idle-high async frames
// (start bit, LSB-first data, optional even parity, stop bit).
// Optional feature macro: TX_RESULTADO_PARIDAD_EN inserts an even-parity bit
// between the last data bit and the stop bit.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line high, ready to accept a word
// S_START  | start bit (line low)
// S_DATA   | data bits, LSB first, shift register drains
// S_PARITY | even-parity bit (only built with the macro)
// S_STOP   | stop bit (line high); done pulse on exit
module tx_resultado #(
    parameter int CANT_BITS_DATO = 8,
    parameter int CLOCKS_POR_BIT = 868
) (
    input  logic           i_clock,
    input  logic           i_reset,
    tx_resultado_if.slave  bus
);
    localparam int CW = (CLOCKS_POR_BIT > 1) ? $clog2(CLOCKS_POR_BIT) : 1;
    localparam int IW = (CANT_BITS_DATO > 1) ? $clog2(CANT_BITS_DATO) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLOCKS_POR_BIT - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(CANT_BITS_DATO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [CANT_BITS_DATO-1:0] shreg_q, shreg_d;
    logic                      tx_q, tx_d;
    logic                      ready_q, ready_d;
    logic                      done_q, done_d;
`ifdef TX_RESULTADO_PARIDAD_EN
    logic                      par_q, par_d;
`endif
    logic                      bit_end;

    assign bit_end = (cnt_q == CNT_MAX);

    // Next-state, bit timing and registered line value for the next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        done_d  = 1'b0;
`ifdef TX_RESULTADO_PARIDAD_EN
        par_d   = par_q;
`endif

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                if (bus.i_valid && ready_q) begin
                    shreg_d = bus.i_dato;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
`ifdef TX_RESULTADO_PARIDAD_EN
                    par_d   = ^bus.i_dato;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_MAX) begin
                        idx_d   = '0;
`ifdef TX_RESULTADO_PARIDAD_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_d[0];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef TX_RESULTADO_PARIDAD_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
`ifdef TX_RESULTADO_PARIDAD_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.o_tx      = tx_q;
    assign bus.o_ready   = ready_q;
    assign bus.o_tx_done = done_q;
endmodule

// File: tb/tb_tx_resultado.sv
// tb_tx_resultado: random and directed frames checked cycle by cycle against
// a frame-level reference (bit n of the frame from the word and bit index).
module tb_tx_resultado;
    localparam int C = 4;
    localparam int N = 8;
`ifdef TX_RESULTADO_PARIDAD_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int F = (2 + N + PAR) * C;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tx_resultado_if #(.CANT_BITS_DATO(N)) bus ();

    tx_resultado #(
        .CANT_BITS_DATO(N),
        .CLOCKS_POR_BIT(C)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bus)
    );

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int done_seen = 0;
    int done_exp  = 0;
    int done_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.o_tx_done === 1'b1) begin
            done_seen++;
            done_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame bit n: 0 = start, 1..N = data LSB first, then parity, then stop.
    function automatic logic exp_bit(input logic [N-1:0] d, input int n);
        if (n == 0) return 1'b0;
        if (n <= N) return d[n-1];
        if (PAR == 1 && n == N + 1) return ^d;
        return 1'b1;
    endfunction

    // Entered at a negedge with the DUT idle. poke_at / rst_at < 0 disable
    // the busy-request pulse and the mid-frame reset. chain leaves i_valid
    // high and returns at the done cycle so the next call is back-to-back.
    task automatic send(input logic [N-1:0] d, input int poke_at, input int rst_at, input bit chain);
        check("ready_pre", bus.o_ready, 1);
        bus.i_dato  = d;
        bus.i_valid = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= F + 1; j++) begin
            @(negedge clk);
            if (j == rst_at + 1) begin
                check("rst_tx", bus.o_tx, 1);
                check("rst_ready", bus.o_ready, 1);
                check("rst_done", bus.o_tx_done, 0);
                rst = 1'b0;
                return;
            end
            if (j <= F) begin
                check("tx", bus.o_tx, exp_bit(d, (j - 1) / C));
                check("busy_ready", bus.o_ready, 0);
                check("done_early", bus.o_tx_done, 0);
            end else begin
                check("tx_end", bus.o_tx, 1);
                check("ready_end", bus.o_ready, 1);
                check("done_pulse", bus.o_tx_done, 1);
                done_exp++;
            end
            if (j == 1 && !chain) bus.i_valid = 1'b0;
            if (j == 2) bus.i_dato = N'($urandom);
            if (j == poke_at) begin
                bus.i_valid = 1'b1;
                bus.i_dato  = '1;
            end
            if (j == poke_at + 1) bus.i_valid = 1'b0;
            if (j == rst_at) rst = 1'b1;
        end
        if (!chain) begin
            @(negedge clk);
            check("done_clr", bus.o_tx_done, 0);
            check("idle_tx", bus.o_tx, 1);
        end
    endtask

    initial begin
        int n0;
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_dato  = '0;
        repeat (3) begin
            @(negedge clk);
            check("reset_tx", bus.o_tx, 1);
            check("reset_ready", bus.o_ready, 1);
            check("reset_done", bus.o_tx_done, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", bus.o_ready, 1);

        send(8'h55, -1, -1, 1'b0);
        send(8'hA3, -1, -1, 1'b0);
        // Busy request of 0xFF during the second data bit.
        send(8'h0F, 2 * C + 2, -1, 1'b0);
        // Reset during the 3rd data bit, then a clean frame.
        send(8'hC6, -1, 3 * C + 2, 1'b0);
        send(8'h81, -1, -1, 1'b0);

        n0 = done_cyc.size();
        send(8'h12, -1, -1, 1'b1);
        send(8'h34, -1, -1, 1'b0);
        check("b2b_count", done_cyc.size() - n0, 2);
        if (done_cyc.size() >= n0 + 2)
            check("b2b_space", done_cyc[n0+1] - done_cyc[n0], F + 1);

        repeat (12) begin
            logic [N-1:0] d;
            int           poke;
            d    = N'($urandom);
            poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, F - 1)) : -1;
            send(d, poke, -1, $urandom_range(0, 3) == 0);
        end
        // A chained last frame leaves i_valid high; drain it and stop.
        bus.i_valid = 1'b0;
        repeat (F + 4) @(negedge clk);
        check("final_idle", bus.o_ready, 1);
        check("done_total", done_seen, done_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
